// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared types and constants for the OV7670 pixel generator
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_GRAD  = 2'd1;
    localparam logic [1:0] PAT_SOLID = 2'd2;

    localparam int C_DEF_COLS = 160;
    localparam int C_DEF_ROWS = 120;

endpackage

// File: rtl/ov7670_pxl_gen_if.sv
// rtl/ov7670_pxl_gen_if.sv - DVP camera bus (pclk/vsync/href/d)
interface ov7670_pxl_gen_if;

    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] d;

    modport master (output pclk, output vsync, output href, output d);
    modport slave  (input  pclk, input  vsync, input  href, input  d);

endinterface

// File: rtl/pxlgen_pattern.sv
// rtl/pxlgen_pattern.sv - combinational RGB444 test-pattern source
module pxlgen_pattern
    import ov7670_pkg::*;
#(
    parameter int c_img_cols = C_DEF_COLS,
    parameter int c_col_w    = 8,
    parameter int c_row_w    = 7
) (
    input  logic [1:0]         pattern,
    input  logic [c_col_w-1:0] col,
    input  logic [c_row_w-1:0] row,
    input  logic [3:0]         frame_cnt,
    input  logic [11:0]        solid_rgb,
    output logic [11:0]        rgb
);

    logic [2:0] bar;

    always_comb begin
        bar = 3'((32'(col) * 8) / c_img_cols);
        case (pattern)
            PAT_BARS:  rgb = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
            PAT_GRAD:  rgb = {4'(col), 4'(row), frame_cnt};
            PAT_SOLID: rgb = solid_rgb;
            default:   rgb = 12'h000;
        endcase
    end

endmodule

// File: rtl/ov7670_pxl_gen.sv
// rtl/ov7670_pxl_gen.sv - OV7670 DVP RGB444 frame generator, pclk = clk/2
// Optional macro PXLGEN_CHECKSUM_EN adds a 16-bit per-frame sum of href bytes.
module ov7670_pxl_gen
    import ov7670_pkg::*;
#(
    parameter int c_img_cols     = C_DEF_COLS,
    parameter int c_img_rows     = C_DEF_ROWS,
    parameter int c_hblank       = 16,
    parameter int c_vsync_lines  = 3,
    parameter int c_vback_lines  = 2,
    parameter int c_vfront_lines = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          pattern,
    input  logic [11:0]         solid_rgb,
    ov7670_pxl_gen_if.master    dvp,
    output logic                frame_done,
    output logic                busy
`ifdef PXLGEN_CHECKSUM_EN
    ,
    output logic [15:0]         checksum
`endif
);

    localparam int LINE_LEN = 2 * c_img_cols + c_hblank;
    localparam int PX_W     = $clog2(LINE_LEN + 1);
    localparam int LN_W     = $clog2(c_img_rows + c_vsync_lines + c_vback_lines + c_vfront_lines + 1);
    localparam int COL_W    = $clog2(c_img_cols + 1);
    localparam int ROW_W    = $clog2(c_img_rows + 1);

    state_t            st_q, st_d;
    logic [PX_W-1:0]   px_q, px_d;
    logic [LN_W-1:0]   ln_q, ln_d;
    logic [3:0]        fcnt_q, fcnt_d;
    logic [1:0]        pat_q, pat_d;
    logic [11:0]       solid_q, solid_d;
    logic              pclk_q, pclk_d;
    logic              vsync_q, vsync_d;
    logic              href_q, href_d;
    logic [7:0]        d_q, d_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;

    int                state_lines;
    logic              line_end, phase_end, in_href;
    logic [COL_W-1:0]  col_d;
    logic [ROW_W-1:0]  row_d;
    logic [11:0]       rgb;

    always_comb begin
        case (st_q)
            ST_VSYNC:  state_lines = c_vsync_lines;
            ST_VBACK:  state_lines = c_vback_lines;
            ST_ACTIVE: state_lines = c_img_rows;
            default:   state_lines = c_vfront_lines;
        endcase
    end

    assign line_end  = (px_q == PX_W'(LINE_LEN - 1));
    assign phase_end = line_end && (ln_q == LN_W'(state_lines - 1));
    assign pclk_d    = ~pclk_q;

    // Everything except pclk advances only on the clk edge where pclk falls.
    always_comb begin
        st_d         = st_q;
        px_d         = px_q;
        ln_d         = ln_q;
        fcnt_d       = fcnt_q;
        pat_d        = pat_q;
        solid_d      = solid_q;
        frame_done_d = 1'b0;
        if (pclk_q) begin
            if (st_q == ST_IDLE) begin
                if (en) begin
                    st_d    = ST_VSYNC;
                    px_d    = '0;
                    ln_d    = '0;
                    pat_d   = pattern;
                    solid_d = solid_rgb;
                end
            end else begin
                px_d = line_end ? '0 : px_q + PX_W'(1);
                if (line_end) ln_d = ln_q + LN_W'(1);
                if (phase_end) begin
                    ln_d = '0;
                    case (st_q)
                        ST_VSYNC:  st_d = ST_VBACK;
                        ST_VBACK:  st_d = ST_ACTIVE;
                        ST_ACTIVE: st_d = ST_VFRONT;
                        default: begin
                            frame_done_d = 1'b1;
                            fcnt_d       = fcnt_q + 4'd1;
                            st_d         = en ? ST_VSYNC : ST_IDLE;
                            if (en) begin
                                pat_d   = pattern;
                                solid_d = solid_rgb;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign col_d   = COL_W'(px_d >> 1);
    assign row_d   = ROW_W'(ln_d);
    assign in_href = (st_d == ST_ACTIVE) && (px_d < PX_W'(2 * c_img_cols));

    pxlgen_pattern #(
        .c_img_cols (c_img_cols),
        .c_col_w    (COL_W),
        .c_row_w    (ROW_W)
    ) u_pattern (
        .pattern   (pat_d),
        .col       (col_d),
        .row       (row_d),
        .frame_cnt (fcnt_d),
        .solid_rgb (solid_d),
        .rgb       (rgb)
    );

    // Outputs reflect the position being entered, so they are stable for the whole pclk period.
    always_comb begin
        vsync_d = vsync_q;
        href_d  = href_q;
        d_d     = d_q;
        busy_d  = busy_q;
        if (pclk_q) begin
            vsync_d = (st_d == ST_VSYNC);
            href_d  = in_href;
            d_d     = in_href ? (px_d[0] ? rgb[7:0] : {4'h0, rgb[11:8]}) : 8'h00;
            busy_d  = (st_d != ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= ST_IDLE;
            px_q         <= '0;
            ln_q         <= '0;
            fcnt_q       <= 4'd0;
            pat_q        <= PAT_BARS;
            solid_q      <= 12'h000;
            pclk_q       <= 1'b0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            d_q          <= 8'h00;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            st_q         <= st_d;
            px_q         <= px_d;
            ln_q         <= ln_d;
            fcnt_q       <= fcnt_d;
            pat_q        <= pat_d;
            solid_q      <= solid_d;
            pclk_q       <= pclk_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            d_q          <= d_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign dvp.pclk   = pclk_q;
    assign dvp.vsync  = vsync_q;
    assign dvp.href   = href_q;
    assign dvp.d      = d_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

`ifdef PXLGEN_CHECKSUM_EN
    logic [15:0] acc_q, acc_d;
    logic [15:0] cks_q, cks_d;

    always_comb begin
        acc_d = acc_q;
        cks_d = cks_q;
        if (pclk_q && href_d) acc_d = acc_q + 16'(d_d);
        if (frame_done_d) begin
            cks_d = acc_q;
            acc_d = 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 16'h0000;
            cks_q <= 16'h0000;
        end else begin
            acc_q <= acc_d;
            cks_q <= cks_d;
        end
    end

    assign checksum = cks_q;
`endif

endmodule

// File: tb/tb_ov7670_pxl_gen.sv
// tb/tb_ov7670_pxl_gen.sv - self-checking bench for ov7670_pxl_gen against a frame-index model
module tb_ov7670_pxl_gen;

    localparam int COLS  = 160;
    localparam int ROWS  = 4;
    localparam int HBL   = 16;
    localparam int VS    = 3;
    localparam int VB    = 2;
    localparam int VF    = 2;
    localparam int LINE  = 2 * COLS + HBL;
    localparam int FRAME = (VS + VB + ROWS + VF) * LINE;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  pattern;
    logic [11:0] solid_rgb;
    logic        frame_done;
    logic        busy;
`ifdef PXLGEN_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    ov7670_pxl_gen_if dvp();

    ov7670_pxl_gen #(
        .c_img_cols     (COLS),
        .c_img_rows     (ROWS),
        .c_hblank       (HBL),
        .c_vsync_lines  (VS),
        .c_vback_lines  (VB),
        .c_vfront_lines (VF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pattern    (pattern),
        .solid_rgb  (solid_rgb),
        .dvp        (dvp),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef PXLGEN_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        if (checks - passes > 40) begin
            $display("%0d/%0d checks passed", passes, checks);
            $finish;
        end
    endtask

    function automatic logic [11:0] model_rgb(input int pat, input int col, input int row,
                                              input int f, input logic [11:0] s);
        int bar;
        logic [3:0] r, g, b;
        case (pat)
            0: begin
                bar = col * 8 / COLS;
                r = ((bar / 4) % 2 == 1) ? 4'hF : 4'h0;
                g = ((bar / 2) % 2 == 1) ? 4'hF : 4'h0;
                b = (bar % 2 == 1) ? 4'hF : 4'h0;
                return {r, g, b};
            end
            1:       return {4'(col % 16), 4'(row % 16), 4'(f % 16)};
            2:       return s;
            default: return 12'h000;
        endcase
    endfunction

    // Model: the frame is a flat sequence of FRAME pclk slots indexed by k.
    bit          armed = 0;
    bit          m_idle;
    int          n, k, fc;
    logic [1:0]  m_pat;
    logic [11:0] m_solid;
    logic        e_vs, e_hr, e_done;
    logic [7:0]  e_d;
    logic [15:0] sum, e_cks;

    always @(posedge clk) begin
        int line, p, row;
        logic [11:0] rgb;
        logic [12:0] exp_v, act_v;
        if (rst) begin
            armed = 1; n = 0; k = 0; m_idle = 1; fc = 0;
            e_vs = 0; e_hr = 0; e_d = 0; e_done = 0; sum = 0; e_cks = 0;
            m_pat = 0; m_solid = 0;
        end else if (armed) begin
            n++;
            e_done = 0;
            if (n % 2 == 0) begin
                if (m_idle) begin
                    if (en) begin
                        m_idle = 0; k = 0; m_pat = pattern; m_solid = solid_rgb;
                    end
                end else if (k == FRAME - 1) begin
                    e_done = 1; e_cks = sum; sum = 0; fc = (fc + 1) % 16;
                    if (en) begin
                        k = 0; m_pat = pattern; m_solid = solid_rgb;
                    end else m_idle = 1;
                end else k++;
                if (m_idle) begin
                    e_vs = 0; e_hr = 0; e_d = 0;
                end else begin
                    line = k / LINE;
                    p    = k % LINE;
                    row  = line - VS - VB;
                    e_vs = (line < VS);
                    e_hr = (row >= 0) && (row < ROWS) && (p < 2 * COLS);
                    rgb  = model_rgb(int'(m_pat), p / 2, row, fc, m_solid);
                    e_d  = e_hr ? ((p % 2 == 0) ? {4'h0, rgb[11:8]} : rgb[7:0]) : 8'h00;
                    if (e_hr) sum = sum + 16'(e_d);
                end
            end
        end
        #1;
        if (armed) begin
            exp_v = {(n % 2 == 1), e_vs, e_hr, e_d, e_done, !m_idle};
            act_v = {dvp.pclk, dvp.vsync, dvp.href, dvp.d, frame_done, busy};
            chk(act_v === exp_v, "cycle {pclk,vsync,href,d,done,busy}", 32'(act_v), 32'(exp_v));
`ifdef PXLGEN_CHECKSUM_EN
            chk(checksum === e_cks, "cycle checksum", 32'(checksum), 32'(e_cks));
`endif
        end
    end

    // Capture-side decoder sampling at pclk rising edges.
    int         cyc = 0;
    int         mon_row, blen;
    logic       prev_href, prev_pclk;
    logic [7:0] row0 [0:2*COLS-1];
    int         lens[$];
    logic [3:0] bq[$];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            mon_row = -1; blen = 0; prev_href = 0; prev_pclk = 0;
        end else begin
            if (dvp.pclk && !prev_pclk) begin
                if (dvp.vsync) mon_row = -1;
                if (dvp.href) begin
                    if (!prev_href) begin
                        mon_row++;
                        blen = 0;
                    end
                    if (mon_row == 0 && blen < 2 * COLS) row0[blen] = dvp.d;
                    if (mon_row == 3 && blen == 11) bq.push_back(dvp.d[3:0]);
                    blen++;
                end else if (prev_href) lens.push_back(blen);
                prev_href = dvp.href;
            end
            prev_pclk = dvp.pclk;
        end
    end

    task automatic wait_done(input string name);
        bit got = 0;
        for (int i = 0; i < 2 * FRAME + 200 && !got; i++) begin
            @(negedge clk);
            if (frame_done) got = 1;
        end
        chk(got, {name, " frame_done"}, 32'(got), 32'd1);
    endtask

    task automatic wait_row(input int r);
        bit got = 0;
        for (int i = 0; i < 2 * FRAME + 200 && !got; i++) begin
            @(negedge clk);
            if (mon_row == r && dvp.href) got = 1;
        end
        chk(got, "reach active row", 32'(got), 32'd1);
    endtask

    task automatic chk_lens(input string name);
        chk(lens.size() == ROWS, {name, " href pulses"}, 32'(lens.size()), 32'(ROWS));
        foreach (lens[i]) chk(lens[i] == 2 * COLS, {name, " bytes per href"}, 32'(lens[i]), 32'(2 * COLS));
    endtask

    initial begin
        int t1, t2, t3;
        rst = 1; en = 0; pattern = 0; solid_rgb = 0;
        repeat (3) @(negedge clk);
        chk({dvp.pclk, dvp.vsync, dvp.href, dvp.d, frame_done, busy} == 13'h0, "reset outputs",
            32'({dvp.pclk, dvp.vsync, dvp.href, dvp.d, frame_done, busy}), 32'h0);

        chk(model_rgb(0, 0, 0, 0, 0) == 12'h000, "model bar col0", 32'(model_rgb(0, 0, 0, 0, 0)), 32'h000);
        chk(model_rgb(0, 19, 0, 0, 0) == 12'h000, "model bar col19", 32'(model_rgb(0, 19, 0, 0, 0)), 32'h000);
        chk(model_rgb(0, 20, 0, 0, 0) == 12'h00F, "model bar col20", 32'(model_rgb(0, 20, 0, 0, 0)), 32'h00F);
        chk(model_rgb(0, 139, 0, 0, 0) == 12'hFF0, "model bar col139", 32'(model_rgb(0, 139, 0, 0, 0)), 32'hFF0);
        chk(model_rgb(0, 159, 0, 0, 0) == 12'hFFF, "model bar col159", 32'(model_rgb(0, 159, 0, 0, 0)), 32'hFFF);
        chk(model_rgb(1, 5, 3, 2, 0) == 12'h532, "model grad", 32'(model_rgb(1, 5, 3, 2, 0)), 32'h532);

        rst = 0;
        repeat (10) @(negedge clk);

        // gradient, three back-to-back frames
        pattern = 1; en = 1; bq.delete();
        wait_done("grad1"); t1 = cyc;
        wait_done("grad2"); t2 = cyc;
        en = 0;
        wait_done("grad3"); t3 = cyc;
        chk(t2 - t1 == 2 * FRAME, "frame_done spacing 1-2", 32'(t2 - t1), 32'(2 * FRAME));
        chk(t3 - t2 == 2 * FRAME, "frame_done spacing 2-3", 32'(t3 - t2), 32'(2 * FRAME));
        repeat (4 * LINE) @(negedge clk);
        chk(busy == 0 && dvp.vsync == 0, "idle after en drop", 32'({busy, dvp.vsync}), 32'h0);
        chk(bq.size() == 3, "pixel(5,3) samples", 32'(bq.size()), 32'd3);
        foreach (bq[i]) chk(bq[i] == 4'(i), "pixel(5,3) B nibble", 32'(bq[i]), 32'(i));

        // solid, with inputs changed mid-frame
        lens.delete();
        pattern = 2; solid_rgb = 12'hA5C; en = 1;
        repeat (100) @(negedge clk);
        pattern = 0; solid_rgb = 12'h000; en = 0;
        wait_done("solid");
        chk_lens("solid");
        chk(row0[0] == 8'h0A, "solid first byte", 32'(row0[0]), 32'h0A);
        chk(row0[1] == 8'h5C, "solid second byte", 32'(row0[1]), 32'h5C);

        // bars, en dropped in active row 2
        lens.delete();
        pattern = 0; en = 1;
        wait_row(2);
        en = 0;
        wait_done("bars");
        chk_lens("bars");
        chk({row0[0], row0[1]} == 16'h0000, "bars col0", 32'({row0[0], row0[1]}), 32'h0000);
        chk({row0[38], row0[39]} == 16'h0000, "bars col19", 32'({row0[38], row0[39]}), 32'h0000);
        chk({row0[40], row0[41]} == 16'h000F, "bars col20", 32'({row0[40], row0[41]}), 32'h000F);
        chk({row0[318], row0[319]} == 16'h0FFF, "bars col159", 32'({row0[318], row0[319]}), 32'h0FFF);
        repeat (2 * LINE) @(negedge clk);
        chk(busy == 0 && dvp.vsync == 0, "bars idle", 32'({busy, dvp.vsync}), 32'h0);

        // reset in the middle of active video
        pattern = 1; en = 1;
        wait_row(2);
        rst = 1;
        @(negedge clk);
        chk({dvp.pclk, dvp.vsync, dvp.href, dvp.d, frame_done, busy} == 13'h0, "mid-frame reset outputs",
            32'({dvp.pclk, dvp.vsync, dvp.href, dvp.d, frame_done, busy}), 32'h0);
        rst = 0;
        lens.delete(); bq.delete();
        repeat (20) @(negedge clk);
        en = 0;
        wait_done("restart");
        chk_lens("restart");
        chk(bq.size() == 1 && bq[0] == 4'd0, "frame counter after reset", 32'(bq.size() == 1 ? bq[0] : 4'hF), 32'h0);

`ifdef PXLGEN_CHECKSUM_EN
        pattern = 2; solid_rgb = 12'h001; en = 1;
        repeat (100) @(negedge clk);
        en = 0;
        wait_done("checksum");
        chk(checksum == 16'(ROWS * COLS), "checksum solid 001", 32'(checksum), 32'(16'(ROWS * COLS)));
`endif

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
